// File: rtl/uart_pkg.sv
// +----------------------------------------------------------------------+
// | uart_pkg                                                             |
// | Types and constants shared by the UART transmitter and receiver.     |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

package uart_pkg;

    localparam int DATA_BITS            = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 16;

    // Encoding is shared with the transmitter so debug views line up.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        DATA  = 2'b10,
        STOP  = 2'b11
    } uart_state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_if.sv
// +----------------------------------------------------------------------+
// | uart_rx_if                                                           |
// | Serial line in, recovered byte stream out.                           |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

interface uart_rx_if;
    import uart_pkg::*;

    logic                 rx_in;
    logic [DATA_BITS-1:0] data;
    logic                 data_valid;
    logic                 frame_err;
    logic                 busy;

    modport master (
        input  rx_in,
        output data,
        output data_valid,
        output frame_err,
        output busy
    );

    modport slave (
        output rx_in,
        input  data,
        input  data_valid,
        input  frame_err,
        input  busy
    );

endinterface

`default_nettype wire

// File: rtl/uart_rx_sync.sv
// +----------------------------------------------------------------------+
// | uart_rx_sync                                                         |
// | Two-flop synchroniser plus edge history; flags the start edge.       |
// | Optional macro: UART_RX_MAJORITY_EN exposes neighbouring samples.    |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic rx_in,
`ifdef UART_RX_MAJORITY_EN
    output logic rx_early,
    output logic rx_late,
`endif
    output logic rx_s,
    output logic fall
);

    logic r_meta;
    logic r_sync;
    logic r_hist;

    // Loading ones makes the line look idle, so reset never fakes a start edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_hist <= 1'b1;
        end else begin
            r_meta <= rx_in;
            r_sync <= r_meta;
            r_hist <= r_sync;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    assign rx_early = r_meta;
    assign rx_late  = r_hist;
`endif
    assign rx_s = r_sync;
    assign fall = ~r_sync & r_hist;

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// +----------------------------------------------------------------------+
// | uart_rx                                                              |
// | 8N1 receiver: mid-bit sampling, one-cycle valid / framing-err pulse. |
// | Optional macro: UART_RX_MAJORITY_EN (2-of-3 vote at each sample).    |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic      clk,
    input  logic      rst_n,
    uart_rx_if.master bus
);

    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int CNT_W    = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] c_cnt_half = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       c_last_bit = 3'(DATA_BITS - 1);

    if (CLKS_PER_BIT < 4 || (CLKS_PER_BIT % 2) != 0) begin : g_bad_clks_per_bit
        $error("uart_rx: CLKS_PER_BIT must be even and >= 4");
    end

    logic w_rx_s;
    logic w_fall;
    logic w_sample;

`ifdef UART_RX_MAJORITY_EN
    logic w_rx_early;
    logic w_rx_late;

    uart_rx_sync u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_in    (bus.rx_in),
        .rx_early (w_rx_early),
        .rx_late  (w_rx_late),
        .rx_s     (w_rx_s),
        .fall     (w_fall)
    );

    // The first sync flop already holds the next cycle's rx_s, so the vote
    // is ready on the nominal cycle and latency does not move.
    assign w_sample = maj3(w_rx_late, w_rx_s, w_rx_early);
`else
    uart_rx_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .rx_in (bus.rx_in),
        .rx_s  (w_rx_s),
        .fall  (w_fall)
    );

    assign w_sample = w_rx_s;
`endif

    uart_state_t          r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [2:0]           r_bit_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_err;
    logic                 r_busy;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_err     <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;

            case (r_state)
                IDLE: begin
                    r_cnt     <= '0;
                    r_bit_idx <= '0;
                    if (w_fall) begin
                        r_state <= START;
                        r_busy  <= 1'b1;
                    end
                end

                START: begin
                    if (r_cnt == c_cnt_half) begin
                        r_cnt     <= '0;
                        r_bit_idx <= '0;
                        if (w_sample) begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= DATA;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (r_cnt == c_cnt_last) begin
                        r_cnt   <= '0;
                        // LSB arrives first, so after the last bit the byte is aligned.
                        r_shift <= {w_sample, r_shift[DATA_BITS-1:1]};
                        if (r_bit_idx == c_last_bit) begin
                            r_state <= STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                STOP: begin
                    if (r_cnt == c_cnt_last) begin
                        r_cnt   <= '0;
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        if (w_sample) begin
                            r_data  <= r_shift;
                            r_valid <= 1'b1;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.data       = r_data;
    assign bus.data_valid = r_valid;
    assign bus.frame_err  = r_err;
    assign bus.busy       = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// +----------------------------------------------------------------------+
// | tb_uart_rx                                                           |
// | Directed frames with a scoreboard of expected valid/err pulses.      |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_uart_rx;

    localparam int CPB     = 16;
    localparam int LATENCY = 155;

    logic clk = 1'b0;
    logic rst_n;

    uart_rx_if bus ();

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
        int         at_cyc;
        int         id;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Every pulse must be predicted by the scoreboard, at the predicted cycle.
    always @(negedge clk) begin
        if (bus.data_valid === 1'b1 || bus.frame_err === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {30'd0, bus.data_valid, bus.frame_err}, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check($sformatf("frame%0d_kind", e.id), {30'd0, bus.data_valid, bus.frame_err},
                      e.is_err ? 32'd1 : 32'd2);
                check($sformatf("frame%0d_cycle", e.id), cyc, e.at_cyc);
                check($sformatf("frame%0d_data", e.id), {24'd0, bus.data}, {24'd0, e.data});
                check($sformatf("frame%0d_busy", e.id), {31'd0, bus.busy}, 32'd0);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int spike_bit,
                              input logic [7:0] exp_data, input int id);
        bus.rx_in = 1'b0;
        exp_q.push_back('{is_err: !stop_bit, data: exp_data, at_cyc: cyc + LATENCY, id: id});
        step(CPB);
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < CPB; j++) begin
                bus.rx_in = (i == spike_bit && j == CPB / 2) ? ~b[i] : b[i];
                step(1);
            end
        end
        bus.rx_in = stop_bit;
        step(CPB);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb;
        int w;
        logic [7:0] exp_spike;

        rst_n     = 1'b0;
        bus.rx_in = 1'b1;
        step(3);
        check("reset_data", {24'd0, bus.data}, 32'd0);
        check("reset_valid", {31'd0, bus.data_valid}, 32'd0);
        check("reset_err", {31'd0, bus.frame_err}, 32'd0);
        check("reset_busy", {31'd0, bus.busy}, 32'd0);
        rst_n = 1'b1;
        step(5);

        // Single frame from idle
        send_frame(8'hA5, 1'b1, -1, 8'hA5, 1);
        step(20);
        check("t1_data_held", {24'd0, bus.data}, 32'h0000_00A5);

        // Back-to-back frames, no idle gap
        send_frame(8'h00, 1'b1, -1, 8'h00, 2);
        send_frame(8'hFF, 1'b1, -1, 8'hFF, 3);
        step(20);

        // Four-clock low glitch while idle
        nb = 0;
        for (int i = 0; i < 34; i++) begin
            bus.rx_in = (i < 4) ? 1'b0 : 1'b1;
            step(1);
            if (bus.busy === 1'b1) nb++;
        end
        check("t3_busy_cycles", nb, 32'd8);
        check("t3_data_kept", {24'd0, bus.data}, 32'h0000_00FF);

        // Framing error, then a held-low line must not retrigger
        send_frame(8'h3C, 1'b0, -1, 8'hFF, 4);
        step(300);
        check("t4_busy_low", {31'd0, bus.busy}, 32'd0);
        check("t4_data_kept", {24'd0, bus.data}, 32'h0000_00FF);
        bus.rx_in = 1'b1;
        step(40);

        // Reset during data bit 4 of 0x55
        bus.rx_in = 1'b0;
        step(CPB);
        for (int i = 0; i < 4; i++) begin
            bus.rx_in = i[0] ? 1'b0 : 1'b1;
            step(CPB);
        end
        bus.rx_in = 1'b1;
        step(4);
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        check("t5_data_reset", {24'd0, bus.data}, 32'd0);
        check("t5_busy_reset", {31'd0, bus.busy}, 32'd0);
        step(200);
        check("t5_idle_busy", {31'd0, bus.busy}, 32'd0);
        send_frame(8'h81, 1'b1, -1, 8'h81, 5);
        step(20);

        // Mid-bit spike on data bit 2 of 0x0F
`ifdef UART_RX_MAJORITY_EN
        exp_spike = 8'h0F;
`else
        exp_spike = 8'h0B;
`endif
        send_frame(8'h0F, 1'b1, 2, exp_spike, 6);
        step(20);

        w = 0;
        while (exp_q.size() != 0 && w < 1000) begin
            step(1);
            w++;
        end
        check("queue_drained", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
